// File: rtl/isram_linebuf_if.sv
// Fetch-side SRAM port plus backing-memory request/ack channel of the instruction line buffer.
interface isram_linebuf_if;
    logic        isram_cs;
    logic [31:3] isram_adr;
    logic        buf_inv;
    logic [63:0] instr_fromsram;
    logic        isram_stall;
    logic        mem_req;
    logic [31:3] mem_adr;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output isram_cs, isram_adr, buf_inv, mem_ack, mem_rdata,
        input  instr_fromsram, isram_stall, mem_req, mem_adr
    );

    modport slave (
        input  isram_cs, isram_adr, buf_inv, mem_ack, mem_rdata,
        output instr_fromsram, isram_stall, mem_req, mem_adr
    );
endinterface

// File: rtl/isram_linebuf.sv
// Fully associative instruction line buffer: 1-cycle hits, stalling req/ack fills on a miss.
// Optional next-line prefetch is enabled by defining ISRAM_LINEBUF_PREFETCH_EN.
module isram_linebuf #(
    parameter int unsigned NUM_ENT = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic           clk,
    input  logic           cpurst,
    isram_linebuf_if.slave bus
);
    localparam int unsigned DAT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PREF = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:3]        tag_q [NUM_ENT];
    logic [DAT_W-1:0]   dat_q [NUM_ENT];
    logic [NUM_ENT-1:0] vld_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               inv_q;

    logic [DAT_W-1:0]   instr_q, instr_nxt;
    logic               stall_q, stall_nxt;
    logic               req_q, req_nxt;
    logic [31:3]        madr_q, madr_nxt;
    logic               wr_c, wr_vld_c;

    logic               hit_c, hit_ok_c, miss_c;
    logic [DAT_W-1:0]   hit_dat_c;

    assign bus.instr_fromsram = instr_q;
    assign bus.isram_stall    = stall_q;
    assign bus.mem_req        = req_q;
    assign bus.mem_adr        = madr_q;

    // Tag lookup across all valid entries; buf_inv turns any hit into a miss.
    always_comb begin
        hit_c     = 1'b0;
        hit_dat_c = '0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (vld_q[PTR_W'(i)] && (tag_q[PTR_W'(i)] == bus.isram_adr)) begin
                hit_c     = 1'b1;
                hit_dat_c = dat_q[PTR_W'(i)];
            end
        end
    end

    assign hit_ok_c = hit_c && !bus.buf_inv;
    assign miss_c   = bus.isram_cs && !hit_ok_c;

`ifdef ISRAM_LINEBUF_PREFETCH_EN
    logic        pf_pend_q, pf_wait_q, pf_merge_q;
    logic [31:3] pf_adr_q;
    logic        pf_hit_c, pf_go_c, pf_miss_c, pf_merge_c, pf_other_c;

    always_comb begin
        pf_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (vld_q[PTR_W'(i)] && (tag_q[PTR_W'(i)] == pf_adr_q)) begin
                pf_hit_c = 1'b1;
            end
        end
    end

    // A demand miss in IDLE always wins over a pending prefetch.
    assign pf_go_c    = pf_pend_q && !pf_hit_c && !miss_c;
    assign pf_miss_c  = (state == PREF) && !pf_wait_q && miss_c;
    assign pf_merge_c = pf_merge_q || (pf_miss_c && (bus.isram_adr == pf_adr_q));
    assign pf_other_c = (pf_wait_q && !pf_merge_q) ||
                        (pf_miss_c && (bus.isram_adr != pf_adr_q));
`endif

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (miss_c) begin
                    state_nxt = FILL;
                end
`ifdef ISRAM_LINEBUF_PREFETCH_EN
                else if (pf_go_c) begin
                    state_nxt = PREF;
                end
`endif
            end
            FILL: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
`ifdef ISRAM_LINEBUF_PREFETCH_EN
            PREF: begin
                if (bus.mem_ack) begin
                    state_nxt = pf_other_c ? FILL : IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_nxt = instr_q;
        stall_nxt = stall_q;
        req_nxt   = req_q;
        madr_nxt  = madr_q;
        wr_c      = 1'b0;
        wr_vld_c  = 1'b0;
        case (state)
            IDLE: begin
                stall_nxt = 1'b0;
                if (bus.isram_cs && hit_ok_c) begin
                    instr_nxt = hit_dat_c;
                end else if (miss_c) begin
                    req_nxt   = 1'b1;
                    madr_nxt  = bus.isram_adr;
                    stall_nxt = 1'b1;
                end
`ifdef ISRAM_LINEBUF_PREFETCH_EN
                else if (pf_go_c) begin
                    req_nxt  = 1'b1;
                    madr_nxt = pf_adr_q;
                end
`endif
            end
            FILL: begin
                if (bus.mem_ack) begin
                    wr_c      = 1'b1;
                    wr_vld_c  = !(inv_q || bus.buf_inv);
                    instr_nxt = bus.mem_rdata;
                    stall_nxt = 1'b0;
                    req_nxt   = 1'b0;
                end
            end
`ifdef ISRAM_LINEBUF_PREFETCH_EN
            PREF: begin
                if (bus.isram_cs && hit_ok_c && !pf_wait_q) begin
                    instr_nxt = hit_dat_c;
                end
                if (pf_miss_c) begin
                    stall_nxt = 1'b1;
                end
                if (bus.mem_ack) begin
                    wr_c     = 1'b1;
                    wr_vld_c = !(inv_q || bus.buf_inv);
                    req_nxt  = 1'b0;
                    if (pf_other_c) begin
                        req_nxt   = 1'b1;
                        madr_nxt  = bus.isram_adr;
                        stall_nxt = 1'b1;
                    end else if (pf_merge_c) begin
                        instr_nxt = bus.mem_rdata;
                        stall_nxt = 1'b0;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Outputs, valid bits and replacement pointer.
    always_ff @(posedge clk) begin
        if (cpurst) begin
            instr_q <= '0;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            madr_q  <= '0;
            vld_q   <= '0;
            ptr_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            instr_q <= instr_nxt;
            stall_q <= stall_nxt;
            req_q   <= req_nxt;
            madr_q  <= madr_nxt;
            if (bus.buf_inv) begin
                vld_q <= '0;
            end
            if (wr_c) begin
                vld_q[ptr_q] <= wr_vld_c;
                ptr_q        <= ptr_q + PTR_W'(1);
            end
            // An invalidate seen while a request is in flight keeps that entry invalid.
            if (wr_c) begin
                inv_q <= 1'b0;
            end else if (bus.buf_inv && (state != IDLE)) begin
                inv_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            tag_q[ptr_q] <= madr_q;
            dat_q[ptr_q] <= bus.mem_rdata;
        end
    end

`ifdef ISRAM_LINEBUF_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (cpurst) begin
            pf_pend_q  <= 1'b0;
            pf_wait_q  <= 1'b0;
            pf_merge_q <= 1'b0;
            pf_adr_q   <= '0;
        end else begin
            if ((state == FILL) && bus.mem_ack) begin
                pf_pend_q <= 1'b1;
                pf_adr_q  <= madr_q + 29'd1;
            end else if (state == IDLE) begin
                pf_pend_q <= 1'b0;
            end
            if ((state == PREF) && bus.mem_ack) begin
                pf_wait_q  <= 1'b0;
                pf_merge_q <= 1'b0;
            end else if (pf_miss_c) begin
                pf_wait_q  <= 1'b1;
                pf_merge_q <= pf_merge_c;
            end
        end
    end
`endif

endmodule

// File: doc/isram_linebuf.md
Name: isram_linebuf

Overview:
- Instruction-side line buffer between the fetch stage's SRAM port (isram_cs/isram_adr/instr_fromsram) and a variable-latency instruction memory.
- Holds NUM_ENT 64-bit doublewords, fully associative.
- Serves hits with the fixed 1-cycle latency fetch expects.
- On a miss, raises isram_stall and fills from backing memory through a req/ack handshake.

Parameters:
- NUM_ENT, 2: number of 64-bit buffer entries (power of two, 2..8).
- PTR_W, 1: log2(NUM_ENT); width of the round-robin replacement pointer.

Ports:
- clk  input  1  core clock
- cpurst  input  1  synchronous active-high reset
- isram_cs  input  1  fetch read request
- isram_adr  input  [31:3]  doubleword address from fetch
- buf_inv  input  1  invalidate all entries (fence.i)
- instr_fromsram  output  64  read data to fetch, registered
- isram_stall  output  1  data for last request not yet available; fetch holds cs/adr stable
- mem_req  output  1  backing-memory read request
- mem_adr  output  [31:3]  backing-memory doubleword address
- mem_ack  input  1  mem_rdata valid; completes current mem_req
- mem_rdata  input  64  backing-memory read data

Behaviour:
- Interface: single clock clk; reset cpurst is synchronous, active-high. All state is updated on posedge clk.
- Reset values:
  - All entry valid bits = 0.
  - instr_fromsram = 0, isram_stall = 0, mem_req = 0, mem_adr = 0.
  - Replacement pointer = 0; FSM = IDLE.
- Lookup: the 29-bit tag is compared against all valid entries each cycle isram_cs=1. Allocation never creates duplicate tags.
- Hit (cycle T, IDLE, no buf_inv):
  - instr_fromsram = entry data at T+1.
  - isram_stall = 0 at T+1.
  - No mem_req issued.
- Miss (cycle T, IDLE):
  - FSM goes IDLE->FILL.
  - mem_req = 1 and mem_adr = isram_adr, both from T+1.
  - isram_stall = 1 from T+1.
- FILL:
  - mem_req and mem_adr are held constant until mem_ack.
  - On mem_ack at cycle A:
    - mem_rdata is written to the entry at the replacement pointer, marked valid; the pointer increments modulo NUM_ENT.
    - At A+1: instr_fromsram = mem_rdata, isram_stall = 0, mem_req = 0, FSM = IDLE.
  - A mem_ack in the first cycle of mem_req (zero wait state) is legal.
  - mem_ack while mem_req = 0 is ignored.
- Back-to-back: a new isram_cs in cycle A+1 is evaluated normally, so minimum miss-to-next-request spacing is 0 idle cycles.
- isram_cs = 0: instr_fromsram holds its last value; isram_stall holds 0.
- buf_inv:
  - Clears all valid bits at the next edge.
  - Takes precedence over a hit in the same cycle: that request is treated as a miss.
  - During FILL: the in-flight fill still completes and returns data to fetch, but the entry is NOT marked valid.
- Replacement pointer: wraps NUM_ENT-1 -> 0.
- isram_adr wrap: 0x1FFFFFFF is an ordinary tag; there is no special case.
- Reset mid-FILL: mem_req = 0 at the next edge. Any later mem_ack for the abandoned request is ignored because FSM = IDLE.
- Protocol violation: fetch changing isram_adr while isram_stall = 1 is not supported. A bench assertion flags it.

Optional Feature:
- Macro: ISRAM_LINEBUF_PREFETCH_EN.
- With the macro: after a demand fill of address X completes, if FSM is IDLE and X+1 (mod 2^29) is not buffered, a PREF state issues mem_req for X+1 into the replacement entry. isram_stall is not asserted for a prefetch.
  - A demand miss to X+1 during PREF merges: stall until that ack, then data is returned as for a demand fill.
  - A demand miss to any other address waits for the prefetch ack, then goes to FILL.
  - A hit during PREF is served normally.
  - buf_inv during PREF: the prefetched data is discarded (not marked valid).
- Without the macro: no PREF state; only demand fills occur.

Test Plan:
- Reset then cs at adr 0x0000100, mem_ack after 3 cycles with rdata 0x11223344_55667788 -> stall high 3 cycles, mem_adr = 0x0000100, instr_fromsram = 0x1122334455667788 on the cycle after ack.
- Repeat cs at adr 0x0000100 -> data next cycle, stall = 0, mem_req never asserted.
- Misses to 0x100, 0x200, then 0x300 with NUM_ENT = 2 -> 0x100 evicted. A re-access to 0x100 misses; 0x300 hits.
- Zero-wait ack (mem_ack in the first mem_req cycle) -> stall exactly 1 cycle.
- buf_inv asserted mid-FILL for adr 0x40 -> data returned to fetch; the next cs to 0x40 misses and reissues mem_req.
- With ISRAM_LINEBUF_PREFETCH_EN: demand 0x1FFFFFFF -> prefetch mem_adr = 0x0000000. A later cs to 0 hits with stall = 0.
